// File: rtl/decode_mux_pkg.sv
// Shared types for the decode stage: instruction payload, format/unit IDs, imm modes.
// Also holds the immediate normaliser applied before an instruction enters the output queue.
package decode_mux_pkg;

   typedef logic [7:0] fmt_t;
   localparam fmt_t FMT_I   = 8'h01;
   localparam fmt_t FMT_B   = 8'h02;
   localparam fmt_t FMT_XL  = 8'h04;
   localparam fmt_t FMT_D   = 8'h08;
   localparam fmt_t FMT_X   = 8'h10;
   localparam fmt_t FMT_XX1 = 8'h20;
   localparam fmt_t FMT_XX2 = 8'h40;
   localparam fmt_t FMT_XX3 = 8'h80;

   localparam logic [3:0] UNIT_ALU = 4'd0;
   localparam logic [3:0] UNIT_BR  = 4'd1;
   localparam logic [3:0] UNIT_LSU = 4'd2;
   localparam logic [3:0] UNIT_FPU = 4'd3;
   localparam logic [3:0] UNIT_SYS = 4'd4;

   typedef enum logic [1:0] {
      IMM_PASS   = 2'b00,
      IMM_SEXT   = 2'b01,
      IMM_SHSEXT = 2'b10,
      IMM_RSVD   = 2'b11
   } imm_mode_e;

   typedef struct packed {
      fmt_t        format;
      logic [5:0]  opcode;
      logic [31:0] addr;
      logic [3:0]  unit;
      logic [7:0]  majId;
      logic [7:0]  minId;
      logic        is64;
      logic [3:0]  pid;
      logic [3:0]  tid;
      logic [3:0]  rw;
      logic [3:0]  isReg;
      logic [83:0] body;
   } inst_t;

   localparam int PAYLOAD_W = $bits(inst_t);

   // body[9:0] holds two register fields and is never touched; the 16-bit imm sits at body[25:10].
   function automatic inst_t normalize_imm(inst_t x, imm_mode_e m);
      inst_t       r;
      logic [15:0] imm;
      r   = x;
      imm = x.body[25:10];
      case (m)
         IMM_SEXT: begin
            r.body[73:10] = {{48{imm[15]}}, imm};
            r.body[83:74] = '0;
         end
         IMM_SHSEXT: begin
            r.body[73:10] = {{32{imm[15]}}, imm, 16'h0000};
            r.body[83:74] = '0;
         end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/decode_format_arbiter_if.sv
// Channel-side and queue-side handshake bundle of the decode format arbiter.
interface decode_format_arbiter_if #(
   parameter int NUM_CH = 3,
   parameter int DEPTH  = 2
);
   import decode_mux_pkg::*;

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                        flush_i;
   logic [NUM_CH-1:0]           valid_i;
   logic [NUM_CH-1:0]           ready_o;
   logic [NUM_CH*PAYLOAD_W-1:0] inst_i;
   logic [NUM_CH*2-1:0]         immMode_i;
   logic                        valid_o;
   logic                        ready_i;
   inst_t                       inst_o;
   logic [CH_W-1:0]             chan_o;
   logic [CNT_W-1:0]            count_o;
   logic                        immErr_o;

   modport master (
      output flush_i, valid_i, inst_i, immMode_i, ready_i,
      input  ready_o, valid_o, inst_o, chan_o, count_o, immErr_o
   );

   modport slave (
      input  flush_i, valid_i, inst_i, immMode_i, ready_i,
      output ready_o, valid_o, inst_o, chan_o, count_o, immErr_o
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at an internal pointer,
// pointer moves past the granted requester when advance_i is set.
module rr_arbiter #(
   parameter int N = 3,
   localparam int W = $clog2(N)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req_i,
   input  logic         advance_i,
   output logic [N-1:0] grant_o,
   output logic [W-1:0] grant_idx_o
);

   logic [W-1:0] ptr_q;
   logic [N-1:0] rot;
   logic         found;
   int           sel;

   // rot[k] is the request of channel (ptr+k) mod N; the lowest set k wins.
   always_comb begin
      rot   = N'({req_i, req_i} >> ptr_q);
      found = 1'b0;
      sel   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            sel   = int'(ptr_q) + k;
         end
      end
      if (sel >= N) sel = sel - N;
      grant_idx_o = W'(sel);
      grant_o     = found ? (N'(1) << grant_idx_o) : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (advance_i) begin
         ptr_q <= (grant_idx_o == W'(N - 1)) ? '0 : grant_idx_o + W'(1);
      end
   end

endmodule

// File: rtl/decode_format_arbiter.sv
// Merges NUM_CH decoder channels round-robin into a DEPTH-entry queue, normalising imms on push.
// Accepts one channel per cycle only when the queue has room (or is popped the same cycle).
module decode_format_arbiter
   import decode_mux_pkg::*;
#(
   parameter int NUM_CH   = 3,
   parameter int DEPTH    = 2,
   parameter int INSTANCE = 0,
   localparam int CH_W    = $clog2(NUM_CH),
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH) + 1
) (
   input logic                      clock_i,
   input logic                      reset_i,
   decode_format_arbiter_if.slave   bus
);

   inst_t            mem_q [DEPTH];
   logic [CH_W-1:0]  chan_mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             immErr_q;

   logic [NUM_CH-1:0] grant;
   logic [CH_W-1:0]   grant_idx;
   logic              space, accept, pop;
   inst_t             sel_inst, norm_inst;
   imm_mode_e         sel_mode;
   logic              unused_instance;

   assign unused_instance = (INSTANCE != 0);

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .clk_i       (clock_i),
      .rst_i       (reset_i),
      .req_i       (bus.valid_i),
      .advance_i   (accept),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   // A full queue can still take a new entry when the head leaves in the same cycle.
   assign space       = (count_q < CNT_W'(DEPTH)) || (bus.valid_o && bus.ready_i);
   assign bus.ready_o = (!reset_i && !bus.flush_i && space) ? grant : '0;
   assign accept      = |(bus.valid_i & bus.ready_o);
   assign pop         = bus.valid_o && bus.ready_i;

   always_comb begin
      sel_inst = '0;
      sel_mode = IMM_PASS;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant[c]) begin
            sel_inst = inst_t'(bus.inst_i[c*PAYLOAD_W +: PAYLOAD_W]);
            sel_mode = imm_mode_e'(bus.immMode_i[c*2 +: 2]);
         end
      end
      norm_inst = normalize_imm(sel_inst, sel_mode);
   end

   always_comb begin
      count_d = count_q;
      if (accept && !pop)      count_d = count_q + CNT_W'(1);
      else if (!accept && pop) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i || bus.flush_i) begin
         count_q  <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         immErr_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         immErr_q <= accept && (sel_mode == IMM_RSVD);
         if (accept) wr_q <= wr_q + PTR_W'(1);
         if (pop)    rd_q <= rd_q + PTR_W'(1);
      end
   end

   // accept is already forced low under reset/flush, so storage needs no reset.
   always_ff @(posedge clock_i) begin
      if (accept) begin
         mem_q[wr_q]      <= norm_inst;
         chan_mem_q[wr_q] <= grant_idx;
      end
   end

   assign bus.valid_o  = (count_q != '0);
   assign bus.count_o  = count_q;
   assign bus.immErr_o = immErr_q;
   assign bus.inst_o   = bus.valid_o ? mem_q[rd_q] : '0;
   assign bus.chan_o   = bus.valid_o ? chan_mem_q[rd_q] : '0;

`ifdef DEBUG_PRINT
   logic log_open = 1'b0;
   always @(posedge clock_i) begin
      if (reset_i) begin
         if (!log_open) begin
            log_open = 1'b1;
            $display("DecodeArb%0d: log opened", INSTANCE);
         end
      end else if (bus.flush_i) begin
         $display("DecodeArb%0d: flush", INSTANCE);
      end else if (accept) begin
         $display("DecodeArb%0d: accept majId=%0h ch=%0d fmt=%0h", INSTANCE, sel_inst.majId, grant_idx, sel_inst.format);
      end
   end
`endif

endmodule

// File: tb/tb_decode_format_arbiter.sv
// Randomised + directed bench for decode_format_arbiter against a queue-based reference model.
module tb_decode_format_arbiter;
   import decode_mux_pkg::*;

   localparam int NCH = 3;
   localparam int DEP = 2;
   localparam int PW  = PAYLOAD_W;

   typedef struct packed {
      inst_t      inst;
      logic [1:0] ch;
   } ent_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   decode_format_arbiter_if #(.NUM_CH(NCH), .DEPTH(DEP)) bus ();

   decode_format_arbiter #(.NUM_CH(NCH), .DEPTH(DEP), .INSTANCE(0)) dut (
      .clock_i (clock),
      .reset_i (reset),
      .bus     (bus.slave)
   );

   int   n_vec  = 0;
   int   n_miss = 0;
   logic check_en = 1'b0;

   // reference model state
   ent_t q[$];
   int   rr_m  = 0;
   logic err_m = 1'b0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic inst_t model_norm(inst_t x, logic [1:0] m);
      inst_t              r;
      logic signed [15:0] imm;
      logic signed [31:0] w;
      logic signed [63:0] v;
      r   = x;
      imm = x.body[25:10];
      if (m == 2'd1 || m == 2'd2) begin
         if (m == 2'd1) begin
            v = imm;
         end else begin
            w = {imm, 16'h0000};
            v = w;
         end
         r.body[73:10] = v;
         r.body[83:74] = '0;
      end
      return r;
   endfunction

   function automatic inst_t rand_inst();
      logic [191:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return inst_t'(r[PW-1:0]);
   endfunction

   // Outputs checked mid-cycle; inputs only change just after the rising edge.
   always @(negedge clock) begin
      logic [NCH-1:0] exp_ready;
      logic           acc;
      int             gch;
      logic           found;
      inst_t          pin;
      logic [1:0]     pm;
      if (check_en) begin
         exp_ready = '0;
         acc       = 1'b0;
         gch       = 0;
         found     = 1'b0;
         if (!reset && !bus.flush_i) begin
            for (int k = 0; k < NCH; k++) begin
               if (!found && bus.valid_i[(rr_m + k) % NCH]) begin
                  found = 1'b1;
                  gch   = (rr_m + k) % NCH;
               end
            end
            if (found && (q.size() < DEP || (q.size() > 0 && bus.ready_i))) begin
               acc            = 1'b1;
               exp_ready[gch] = 1'b1;
            end
         end
         chk("ready_o",  bus.ready_o,  exp_ready);
         chk("valid_o",  bus.valid_o,  q.size() > 0);
         chk("count_o",  bus.count_o,  q.size());
         chk("immErr_o", bus.immErr_o, err_m);
         chk("inst_o",   bus.inst_o,   (q.size() > 0) ? q[0].inst : '0);
         chk("chan_o",   bus.chan_o,   (q.size() > 0) ? q[0].ch : 2'd0);

         if (reset) begin
            q.delete();
            rr_m  = 0;
            err_m = 1'b0;
         end else if (bus.flush_i) begin
            q.delete();
            err_m = 1'b0;
         end else begin
            if (q.size() > 0 && bus.ready_i) void'(q.pop_front());
            err_m = 1'b0;
            if (acc) begin
               pin = inst_t'(bus.inst_i[gch*PW +: PW]);
               pm  = bus.immMode_i[gch*2 +: 2];
               q.push_back('{inst: model_norm(pin, pm), ch: 2'(gch)});
               rr_m  = (gch + 1) % NCH;
               err_m = (pm == 2'b11);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ch(input int c, input logic v, input inst_t p, input logic [1:0] m);
      bus.valid_i[c]             = v;
      bus.inst_i[c*PW +: PW]     = p;
      bus.immMode_i[c*2 +: 2]    = m;
   endtask

   inst_t          p, p1, p2, p4;
   logic [2:0]     gexp [6];

   initial begin
      bus.flush_i   = 1'b0;
      bus.valid_i   = '0;
      bus.inst_i    = '0;
      bus.immMode_i = '0;
      bus.ready_i   = 1'b0;
      reset         = 1'b1;
      tick();
      check_en = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst count", bus.count_o, 0);
      chk("rst valid", bus.valid_o, 0);
      chk("rst immErr", bus.immErr_o, 0);
      chk("rst inst", bus.inst_o, 0);
      chk("rst chan", bus.chan_o, 0);
      #1 chk("rst ready", bus.ready_o, 0);

      // mode 01, imm FFFE on ch0
      p = rand_inst(); p.body[25:10] = 16'hFFFE;
      set_ch(0, 1'b1, p, 2'b01);
      bus.ready_i = 1'b1;
      #1 chk("t1 ready", bus.ready_o, 3'b001);
      tick();
      bus.valid_i = '0;
      chk("t1 valid", bus.valid_o, 1);
      chk("t1 count", bus.count_o, 1);
      chk("t1 chan", bus.chan_o, 0);
      chk("t1 imm", bus.inst_o.body[73:10], 64'hFFFF_FFFF_FFFF_FFFE);
      chk("t1 hi", bus.inst_o.body[83:74], 0);
      chk("t1 regs", bus.inst_o.body[9:0], p.body[9:0]);
      tick();
      chk("t1 drain", bus.count_o, 0);

      // mode 10, imm 8001 on ch0
      p = rand_inst(); p.body[25:10] = 16'h8001;
      set_ch(0, 1'b1, p, 2'b10);
      tick();
      bus.valid_i = '0;
      chk("t2 imm", bus.inst_o.body[73:10], 64'hFFFF_FFFF_8001_0000);
      tick();

      // mode 10, imm 0001 on ch2 (leaves the rr pointer at 0)
      p = rand_inst(); p.body[25:10] = 16'h0001;
      set_ch(2, 1'b1, p, 2'b10);
      tick();
      bus.valid_i = '0;
      chk("t3 imm", bus.inst_o.body[73:10], 64'h0000_0000_0001_0000);
      chk("t3 chan", bus.chan_o, 2);
      tick();

      // all channels valid: strict rotation
      gexp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, rand_inst(), 2'b00);
      for (int i = 0; i < 6; i++) begin
         #1 chk("rr grant", bus.ready_o, gexp[i]);
         tick();
         chk("rr chan", bus.chan_o, i % 3);
      end
      bus.valid_i = '0;
      tick();
      chk("rr drain", bus.count_o, 0);

      // back-pressure: ch1 fills the queue
      bus.ready_i = 1'b0;
      p1 = rand_inst(); p2 = rand_inst();
      set_ch(1, 1'b1, p1, 2'b00);
      #1 chk("bp ready0", bus.ready_o, 3'b010);
      tick();
      set_ch(1, 1'b1, p2, 2'b00);
      #1 chk("bp ready1", bus.ready_o, 3'b010);
      tick();
      set_ch(1, 1'b1, rand_inst(), 2'b00);
      chk("bp count", bus.count_o, 2);
      #1 chk("bp full ready", bus.ready_o, 3'b000);
      tick();
      chk("bp head stable", bus.inst_o, p1);
      chk("bp count2", bus.count_o, 2);
      bus.ready_i = 1'b1;
      #1 chk("bp pushpop", bus.ready_o, 3'b010);
      tick();
      bus.ready_i = 1'b0;
      chk("bp count kept", bus.count_o, 2);
      chk("bp new head", bus.inst_o, p2);

      // flush with ch0 valid
      bus.valid_i = '0;
      set_ch(0, 1'b1, rand_inst(), 2'b00);
      bus.flush_i = 1'b1;
      #1 chk("fl ready", bus.ready_o, 3'b000);
      tick();
      bus.flush_i = 1'b0;
      chk("fl count", bus.count_o, 0);
      chk("fl valid", bus.valid_o, 0);
      #1 chk("fl ready after", bus.ready_o, 3'b001);
      tick();
      bus.valid_i = '0;
      chk("fl accepted", bus.count_o, 1);
      chk("fl chan", bus.chan_o, 0);
      bus.ready_i = 1'b1;
      tick();
      bus.ready_i = 1'b0;

      // reserved imm mode on ch2
      p4 = rand_inst();
      set_ch(2, 1'b1, p4, 2'b11);
      tick();
      bus.valid_i = '0;
      chk("err pulse", bus.immErr_o, 1);
      chk("err payload", bus.inst_o, p4);
      tick();
      chk("err clear", bus.immErr_o, 0);
      chk("err count", bus.count_o, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst mid valid", bus.valid_o, 0);
      chk("rst mid count", bus.count_o, 0);

      // randomised traffic
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NCH; c++)
            set_ch(c, 1'($urandom_range(0, 1)), rand_inst(), 2'($urandom_range(0, 3)));
         bus.ready_i = ($urandom_range(0, 9) < 7);
         bus.flush_i = ($urandom_range(0, 39) == 0);
         reset       = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0;
      tick();
      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
